// File: rtl/issue_controller.sv
// rtl/issue_controller.sv - scoreboard issue gate with RAW/WAW/inflight hazards and writeback bypass
// Optional stall statistic enabled by macro ISSUE_CONTROLLER_STATS_EN.
module issue_controller #(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_opcode,
  input  logic [3:0]  i_rs1,
  input  logic [3:0]  i_rs2,
  input  logic [3:0]  i_rd,
  input  logic        i_flush,
  input  logic        i_wb_valid,
  input  logic [3:0]  i_wb_rd,
  output logic        o_ready,
  output logic        o_issue,
  output logic [15:0] o_busy,
  output logic [3:0]  o_inflight,
  output logic        o_wb_err,
  output logic [15:0] o_stall_count
);

  localparam logic [7:0] OP_LDA = 8'd1;
  localparam logic [7:0] OP_STA = 8'd2;
  localparam logic [7:0] OP_ADD = 8'd3;
  localparam logic [7:0] OP_SUB = 8'd4;

  logic        reads_rs1, reads_rs2, writes_rd;
  logic [15:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        wb_err_q, wb_err_d;
  logic [15:0] wb_mask, eff_busy;
  logic [3:0]  eff_inflight;
  logic        wb_legal, raw_hazard, wr_block, ready, issue_wr;

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (i_opcode)
      OP_LDA: writes_rd = 1'b1;
      OP_STA: reads_rs1 = 1'b1;
      OP_ADD, OP_SUB: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // A writeback completing this cycle releases its register to the issuing instruction.
  always_comb begin
    wb_mask      = i_wb_valid ? (16'h0001 << i_wb_rd) : 16'h0000;
    eff_busy     = busy_q & ~wb_mask;
    wb_legal     = i_wb_valid & busy_q[i_wb_rd];
    eff_inflight = inflight_q - {3'b000, wb_legal};
    raw_hazard   = (reads_rs1 & eff_busy[i_rs1]) | (reads_rs2 & eff_busy[i_rs2]);
    wr_block     = writes_rd & (eff_busy[i_rd] | (eff_inflight >= 4'(MAX_INFLIGHT)));
    ready        = i_reset_n & ~i_flush & ~raw_hazard & ~wr_block;
    issue_wr     = i_valid & ready & writes_rd;
  end

  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    wb_err_d   = wb_err_q | (i_wb_valid & ~busy_q[i_wb_rd]);
    if (i_flush) begin
      busy_d     = 16'h0000;
      inflight_d = 4'd0;
    end else begin
      if (wb_legal) busy_d[i_wb_rd] = 1'b0;
      if (issue_wr) busy_d[i_rd] = 1'b1;
      inflight_d = inflight_q + {3'b000, issue_wr} - {3'b000, wb_legal};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      busy_q     <= 16'h0000;
      inflight_q <= 4'd0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

`ifdef ISSUE_CONTROLLER_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (i_valid && !ready && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) stall_count_q <= 16'h0000;
    else            stall_count_q <= stall_count_d;
  end

  assign o_stall_count = stall_count_q;
`else
  assign o_stall_count = 16'h0000;
`endif

  assign o_ready    = ready;
  assign o_issue    = i_valid & ready;
  assign o_busy     = busy_q;
  assign o_inflight = inflight_q;
  assign o_wb_err   = wb_err_q;

endmodule

// File: tb/tb_issue_controller.sv
// tb/tb_issue_controller.sv - directed self-checking bench for issue_controller
module tb_issue_controller;

  localparam logic [7:0] NOP = 8'd0, LDA = 8'd1, STA = 8'd2, ADD = 8'd3, SUB = 8'd4;

`ifdef ISSUE_CONTROLLER_STATS_EN
  localparam logic [15:0] EXP_STALL5 = 16'd5;
`else
  localparam logic [15:0] EXP_STALL5 = 16'd0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_valid, i_flush, i_wb_valid;
  logic [7:0]  i_opcode;
  logic [3:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
  logic        ready, issue, wb_err, ready4, issue4, wb_err4;
  logic [15:0] busy, stall, busy4, stall4;
  logic [3:0]  inflight, inflight4;

  int total = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  issue_controller #(.MAX_INFLIGHT(3)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .o_ready(ready), .o_issue(issue),
    .o_busy(busy), .o_inflight(inflight), .o_wb_err(wb_err), .o_stall_count(stall)
  );

  issue_controller #(.MAX_INFLIGHT(4)) dut4 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .o_ready(ready4), .o_issue(issue4),
    .o_busy(busy4), .o_inflight(inflight4), .o_wb_err(wb_err4), .o_stall_count(stall4)
  );

  task automatic drive(input logic v, input logic [7:0] op, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd, input logic fl,
                       input logic wbv, input logic [3:0] wbrd);
    i_valid = v; i_opcode = op; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_flush = fl; i_wb_valid = wbv; i_wb_rd = wbrd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_reset_n = 1'b0;
    idle();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0);
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", ready); else passed++;
    tick(); tick();
    total++; if (busy !== 16'h0000) $display("FAIL reset_busy: got %h exp 0000", busy); else passed++;
    total++; if (inflight !== 4'd0) $display("FAIL reset_inflight: got %0d exp 0", inflight); else passed++;
    total++; if (wb_err !== 1'b0) $display("FAIL reset_wb_err: got %b exp 0", wb_err); else passed++;
    total++; if (stall !== 16'h0000) $display("FAIL reset_stall: got %0d exp 0", stall); else passed++;
    i_reset_n = 1'b1;
    idle();
  endtask

  task automatic test_raw();
    drive(1'b1, ADD, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd0);
    total++; if (issue !== 1'b1) $display("FAIL raw_add_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (busy !== 16'h0004) $display("FAIL raw_busy: got %h exp 0004", busy); else passed++;
    drive(1'b1, SUB, 4'd2, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0);
    total++; if (ready !== 1'b0) $display("FAIL raw_stall: got %b exp 0", ready); else passed++;
    tick();
    total++; if (ready !== 1'b0) $display("FAIL raw_stall2: got %b exp 0", ready); else passed++;
    drive(1'b1, SUB, 4'd2, 4'd0, 4'd3, 1'b0, 1'b1, 4'd2);
    total++; if (issue !== 1'b1) $display("FAIL raw_bypass_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (busy !== 16'h0008) $display("FAIL raw_after_busy: got %h exp 0008", busy); else passed++;
    total++; if (inflight !== 4'd1) $display("FAIL raw_after_inflight: got %0d exp 1", inflight); else passed++;
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
    tick();
    total++; if (busy !== 16'h0000) $display("FAIL raw_drain_busy: got %h exp 0000", busy); else passed++;
    idle();
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 4'd0);
    total++; if (issue !== 1'b1) $display("FAIL nfh_lda_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (busy !== 16'h0021) $display("FAIL nfh_busy: got %h exp 0021", busy); else passed++;
    drive(1'b1, STA, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    total++; if (issue !== 1'b1) $display("FAIL nfh_sta_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (inflight !== 4'd2) $display("FAIL nfh_sta_inflight: got %0d exp 2", inflight); else passed++;
    drive(1'b1, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    total++; if (issue !== 1'b1) $display("FAIL nfh_nop_issue: got %b exp 1", issue); else passed++;
    drive(1'b1, 8'hFF, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd0);
    total++; if (issue !== 1'b1) $display("FAIL nfh_undef_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (busy !== 16'h0021) $display("FAIL nfh_undef_busy: got %h exp 0021", busy); else passed++;
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0);
    tick();
    idle();
  endtask

  task automatic test_inflight_limit();
    for (int r = 1; r <= 3; r++) begin
      drive(1'b1, LDA, 4'd0, 4'd0, 4'(r), 1'b0, 1'b0, 4'd0);
      tick();
    end
    total++; if (inflight !== 4'd3) $display("FAIL lim_inflight: got %0d exp 3", inflight); else passed++;
    total++; if (busy !== 16'h000E) $display("FAIL lim_busy: got %h exp 000e", busy); else passed++;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 4'd0);
    total++; if (ready !== 1'b0) $display("FAIL lim_stall: got %b exp 0", ready); else passed++;
    total++; if (ready4 !== 1'b1) $display("FAIL lim_max4_ready: got %b exp 1", ready4); else passed++;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd4, 1'b0, 1'b1, 4'd1);
    total++; if (issue !== 1'b1) $display("FAIL lim_wb_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (inflight !== 4'd3) $display("FAIL lim_wb_inflight: got %0d exp 3", inflight); else passed++;
    total++; if (busy !== 16'h001C) $display("FAIL lim_wb_busy: got %h exp 001c", busy); else passed++;
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0);
    tick();
    idle();
  endtask

  task automatic test_waw();
    pulse_reset();
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 4'd0);
    total++; if (ready !== 1'b0) $display("FAIL waw_stall: got %b exp 0", ready); else passed++;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd7, 1'b0, 1'b1, 4'd7);
    total++; if (issue !== 1'b1) $display("FAIL waw_bypass_issue: got %b exp 1", issue); else passed++;
    tick();
    total++; if (busy !== 16'h0080) $display("FAIL waw_set_wins: got %h exp 0080", busy); else passed++;
    total++; if (inflight !== 4'd1) $display("FAIL waw_inflight: got %0d exp 1", inflight); else passed++;
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0);
    tick();
    idle();
  endtask

  task automatic test_err_flush();
    pulse_reset();
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd9);
    tick();
    total++; if (wb_err4 !== 1'b1) $display("FAIL err_set: got %b exp 1", wb_err4); else passed++;
    total++; if (busy4 !== 16'h0000) $display("FAIL err_busy: got %h exp 0000", busy4); else passed++;
    total++; if (inflight4 !== 4'd0) $display("FAIL err_inflight: got %0d exp 0", inflight4); else passed++;
    for (int r = 4; r <= 7; r++) begin
      drive(1'b1, LDA, 4'd0, 4'd0, 4'(r), 1'b0, 1'b0, 4'd0);
      tick();
    end
    total++; if (busy4 !== 16'h00F0) $display("FAIL err_busy_f0: got %h exp 00f0", busy4); else passed++;
    total++; if (inflight4 !== 4'd4) $display("FAIL err_inflight4: got %0d exp 4", inflight4); else passed++;
    total++; if (wb_err4 !== 1'b1) $display("FAIL err_persist: got %b exp 1", wb_err4); else passed++;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 4'd0);
    total++; if (ready4 !== 1'b0) $display("FAIL flush_ready: got %b exp 0", ready4); else passed++;
    tick();
    total++; if (busy4 !== 16'h0000) $display("FAIL flush_busy: got %h exp 0000", busy4); else passed++;
    total++; if (inflight4 !== 4'd0) $display("FAIL flush_inflight: got %0d exp 0", inflight4); else passed++;
    total++; if (wb_err4 !== 1'b1) $display("FAIL flush_keeps_err: got %b exp 1", wb_err4); else passed++;
    idle();
  endtask

  task automatic test_stats_reset();
    pulse_reset();
    for (int r = 1; r <= 3; r++) begin
      drive(1'b1, LDA, 4'd0, 4'd0, 4'(r), 1'b0, 1'b0, 4'd0);
      tick();
    end
    drive(1'b0, NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd9);
    tick();
    total++; if (wb_err !== 1'b1) $display("FAIL stats_err: got %b exp 1", wb_err); else passed++;
    drive(1'b1, LDA, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 5; c++) tick();
    total++; if (stall !== EXP_STALL5) $display("FAIL stats_count: got %0d exp %0d", stall, EXP_STALL5); else passed++;
    i_reset_n = 1'b0;
    #1;
    total++; if (ready !== 1'b0) $display("FAIL stats_reset_ready: got %b exp 0", ready); else passed++;
    tick();
    total++; if (busy !== 16'h0000) $display("FAIL stats_reset_busy: got %h exp 0000", busy); else passed++;
    total++; if (inflight !== 4'd0) $display("FAIL stats_reset_inflight: got %0d exp 0", inflight); else passed++;
    total++; if (wb_err !== 1'b0) $display("FAIL stats_reset_err: got %b exp 0", wb_err); else passed++;
    total++; if (stall !== 16'h0000) $display("FAIL stats_reset_count: got %0d exp 0", stall); else passed++;
    i_reset_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_no_false_hazard();
    test_inflight_limit();
    test_waw();
    test_err_flush();
    test_stats_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
